frame_scheduler: RTL and testbench
==================================

FRAME_SCHEDULER -- requirements
Module: frame_scheduler

Interface
REQ-001 SHALL have parameter TICK_FRAMES, default 4: display frames per game tick; legal range 1..255.
REQ-002 SHALL have port clk, input, 1 bit: 12 MHz system clock; the only clock.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port frame_start, input, 1 bit: one-cycle pulse from the display driver at row 0, col 0.
REQ-005 SHALL have port upd_valid, input, 1 bit: game logic offers a new state.
REQ-006 SHALL have port upd_ready, output, 1 bit: scheduler accepts the offered state this cycle.
REQ-007 SHALL have ports upd_x and upd_y, input, 5 bits each: offered ball position.
REQ-008 SHALL have ports upd_lpaddle and upd_rpaddle, input, 32 bits each: offered paddle bitmaps.
REQ-009 SHALL have ports disp_x and disp_y, output, 5 bits each: committed ball position for the display.
REQ-010 SHALL have ports disp_lpaddle and disp_rpaddle, output, 32 bits each: committed paddle bitmaps.
REQ-011 SHALL have port game_tick, output, 1 bit: one-cycle pulse that advances game logic.
REQ-012 SHALL have port miss_count, output, 8 bits: saturating count of game ticks that game logic did not answer.

Function
REQ-013 SHALL implement a two-state FSM: IDLE (staging empty) and PENDING (staging holds an update not yet shown).
REQ-014 SHALL drive upd_ready = (state == IDLE) && !reset, combinationally.
REQ-015 SHALL, when upd_valid && upd_ready, capture all four upd_* fields into the staging registers and enter PENDING next cycle.
REQ-016 SHALL, in PENDING on frame_start, copy staging to all disp_* registers in that cycle (visible next cycle) and return to IDLE.
REQ-017 SHALL change disp_* only on a PENDING frame_start, so the display never shows a partial or mid-frame update.
REQ-018 SHALL NOT bypass staging: a handshake in the same cycle as frame_start in IDLE is committed at the next frame_start, not the current one.
REQ-019 SHALL hold staging unchanged and keep upd_ready low in PENDING, regardless of upd_valid or the upd_* inputs.
REQ-020 SHALL keep a frame counter 0..TICK_FRAMES-1 that advances only on frame_start.
REQ-021 SHALL, on frame_start with counter == TICK_FRAMES-1, reset the counter to 0 and assert game_tick for exactly the next cycle.
REQ-022 SHALL, with TICK_FRAMES = 1, pulse game_tick one cycle after every frame_start.
REQ-023 SHALL set an outstanding flag when game_tick is asserted and clear it on an accepted handshake.
REQ-024 SHALL increment miss_count when game_tick asserts while outstanding is already set; miss_count saturates at 255 and never wraps.
REQ-025 SHALL, when game_tick and a handshake occur in the same cycle, count no miss and leave outstanding set (the new tick is unanswered).
REQ-026 SHALL ignore upd_valid while frame_start is absent except as defined in REQ-015; frame_start has no effect on staging in IDLE.

Reset
REQ-027 SHALL, while reset is high at a clk edge, force: state IDLE, staging 0, disp_x/disp_y/disp_lpaddle/disp_rpaddle 0, counter 0, game_tick 0, outstanding 0, miss_count 0.
REQ-028 SHALL discard a PENDING update when reset occurs mid-operation; it is never displayed.
REQ-029 SHALL give reset priority over frame_start and handshake in the same cycle.

Structure
REQ-030 SHALL take the FSM state encoding (IDLE=0, PENDING=1) and the miss_count saturation value from the shared pong package.
REQ-031 SHALL place the frame counter, game_tick generation and miss logic in one sub-module, tick_divider, parameterised by TICK_FRAMES.
REQ-032 SHALL be fully synchronous to clk, with no latches and no derived clocks.

Verification
REQ-033 SHALL verify handshake then commit: handshake x=5, y=9, lpaddle=0x000F0000 in IDLE -> upd_ready=0 next cycle; disp_* unchanged until frame_start; new values one cycle after frame_start; upd_ready=1.
REQ-034 SHALL verify simultaneous events: handshake in the same cycle as frame_start in IDLE -> disp_* unchanged; commit only at the following frame_start.
REQ-035 SHALL verify tick cadence: TICK_FRAMES=4, 12 frame_starts -> exactly 3 game_tick pulses, each one cycle wide, one cycle after the 4th, 8th and 12th frame_start.
REQ-036 SHALL verify misses: 300 game_ticks with upd_valid held low -> miss_count = 255 (saturated); one handshake then one tick -> still 255, no wrap.
REQ-037 SHALL verify reset mid-operation: reset asserted while PENDING with x=3 -> after a later frame_start, disp_x=0 and upd_ready=1.
REQ-038 SHALL verify the PENDING stall: upd_valid held high with changing data in PENDING -> staging holds the first accepted data, and exactly that data is committed.

Source files
------------

// File: rtl/pong_pkg.sv
// ---------------------------------------------------------------------------
// pong_pkg : shared scheduler state encoding, frame record and miss saturation
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pong_pkg;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } sched_state_e;

  localparam logic [7:0] c_MISS_SAT = 8'd255;

  typedef struct packed {
    logic [4:0]  x;
    logic [4:0]  y;
    logic [31:0] lpaddle;
    logic [31:0] rpaddle;
  } frame_state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == c_MISS_SAT) ? v : v + 8'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/frame_scheduler_tick_divider.sv
// ---------------------------------------------------------------------------
// tick_divider : frame counter, game_tick pulse and unanswered-tick counting
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tick_divider
  import pong_pkg::*;
#(
  parameter int unsigned TICK_FRAMES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_start_i,
  input  logic       handshake_i,
  output logic       game_tick_o,
  output logic [7:0] miss_count_o
);

  localparam logic [7:0] c_LAST = 8'(TICK_FRAMES - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       tick_q, tick_d;
  logic       outstanding_q, outstanding_d;
  logic [7:0] miss_q, miss_d;

  always_comb begin
    cnt_d         = cnt_q;
    tick_d        = 1'b0;
    outstanding_d = outstanding_q;
    miss_d        = miss_q;

    if (frame_start_i) begin
      if (cnt_q == c_LAST) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end

    // A fresh tick always leaves the flag set, even if answered in the same cycle.
    if (tick_q) begin
      outstanding_d = 1'b1;
      if (outstanding_q && !handshake_i) begin
        miss_d = sat_inc(miss_q);
      end
    end else if (handshake_i) begin
      outstanding_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q         <= '0;
      tick_q        <= 1'b0;
      outstanding_q <= 1'b0;
      miss_q        <= '0;
    end else begin
      cnt_q         <= cnt_d;
      tick_q        <= tick_d;
      outstanding_q <= outstanding_d;
      miss_q        <= miss_d;
    end
  end

  assign game_tick_o  = tick_q;
  assign miss_count_o = miss_q;

endmodule

`default_nettype wire

// File: rtl/frame_scheduler.sv
// ---------------------------------------------------------------------------
// frame_scheduler : stages game-state updates and commits them at frame start
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module frame_scheduler
  import pong_pkg::*;
#(
  parameter int unsigned TICK_FRAMES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [4:0]  upd_x,
  input  logic [4:0]  upd_y,
  input  logic [31:0] upd_lpaddle,
  input  logic [31:0] upd_rpaddle,
  output logic [4:0]  disp_x,
  output logic [4:0]  disp_y,
  output logic [31:0] disp_lpaddle,
  output logic [31:0] disp_rpaddle,
  output logic        game_tick,
  output logic [7:0]  miss_count
);

  sched_state_e state_q, state_d;
  frame_state_t stage_q;
  frame_state_t disp_q;
  logic         handshake;
  logic         load_stage;
  logic         commit;

  assign upd_ready = (state_q == ST_IDLE) && !reset;
  assign handshake = upd_valid && upd_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Staging is never bypassed: a capture always waits for a later frame_start.
  always_comb begin
    state_d    = state_q;
    load_stage = 1'b0;
    commit     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (handshake) begin
          load_stage = 1'b1;
          state_d    = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (frame_start) begin
          commit  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q <= '0;
      disp_q  <= '0;
    end else begin
      if (load_stage) begin
        stage_q <= '{x: upd_x, y: upd_y, lpaddle: upd_lpaddle, rpaddle: upd_rpaddle};
      end
      if (commit) begin
        disp_q <= stage_q;
      end
    end
  end

  assign disp_x       = disp_q.x;
  assign disp_y       = disp_q.y;
  assign disp_lpaddle = disp_q.lpaddle;
  assign disp_rpaddle = disp_q.rpaddle;

  tick_divider #(
    .TICK_FRAMES (TICK_FRAMES)
  ) u_tick_divider (
    .clk           (clk),
    .reset         (reset),
    .frame_start_i (frame_start),
    .handshake_i   (handshake),
    .game_tick_o   (game_tick),
    .miss_count_o  (miss_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_frame_scheduler : random + directed stimulus, scoreboard on commits/ticks
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_frame_scheduler;

  localparam int TF = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start;
  logic        upd_valid;
  logic        upd_ready;
  logic [4:0]  upd_x, upd_y;
  logic [31:0] upd_lpaddle, upd_rpaddle;
  logic [4:0]  disp_x, disp_y;
  logic [31:0] disp_lpaddle, disp_rpaddle;
  logic        game_tick;
  logic [7:0]  miss_count;

  frame_scheduler #(.TICK_FRAMES(TF)) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_start  (frame_start),
    .upd_valid    (upd_valid),
    .upd_ready    (upd_ready),
    .upd_x        (upd_x),
    .upd_y        (upd_y),
    .upd_lpaddle  (upd_lpaddle),
    .upd_rpaddle  (upd_rpaddle),
    .disp_x       (disp_x),
    .disp_y       (disp_y),
    .disp_lpaddle (disp_lpaddle),
    .disp_rpaddle (disp_rpaddle),
    .game_tick    (game_tick),
    .miss_count   (miss_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ticks_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard queues: expected display values and expected tick cycles.
  logic [73:0] exp_disp_q[$];
  int          exp_tick_q[$];

  // Reference model: one staging slot, a frame count and a tick bookkeeping.
  bit          m_pend = 0;
  logic [73:0] m_stage = '0;
  logic [73:0] m_disp = '0;
  int          m_cnt = 0;
  bit          m_tick_now = 0;
  bit          m_out = 0;
  int          m_miss = 0;

  bit          mon_en = 0;
  logic [73:0] prev_disp;
  logic [73:0] cur_disp;

  task automatic chk(string name, logic [73:0] act, logic [73:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [73:0] rnd_data();
    logic [73:0] d;
    d = {5'($urandom), 5'($urandom), 32'($urandom), 32'($urandom)};
    return d;
  endfunction

  // Monitor: every display change or tick pulse must match the next expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      cur_disp = {disp_x, disp_y, disp_lpaddle, disp_rpaddle};
      if (cur_disp !== prev_disp) begin
        if (exp_disp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_commit: got %0h expected no change", cur_disp);
        end else begin
          chk("disp_commit", cur_disp, exp_disp_q.pop_front());
        end
        prev_disp = cur_disp;
      end
      if (game_tick !== 1'b0) begin
        ticks_seen++;
        if (exp_tick_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_tick: got tick at cycle %0d expected none", cyc);
        end else begin
          chk("tick_cycle", 74'(cyc), 74'(exp_tick_q.pop_front()));
        end
      end
    end
  end

  task automatic step(bit rst, bit fs, bit v, logic [73:0] d);
    bit hs;
    reset       = rst;
    frame_start = fs;
    upd_valid   = v;
    {upd_x, upd_y, upd_lpaddle, upd_rpaddle} = d;
    @(negedge clk);
    chk("upd_ready", 74'(upd_ready), 74'(!m_pend && !rst));
    chk("miss_count", 74'(miss_count), 74'(m_miss));
    hs = v && !m_pend && !rst;
    @(posedge clk);
    if (rst) begin
      if (m_disp != '0) exp_disp_q.push_back('0);
      m_pend = 0; m_stage = '0; m_disp = '0; m_cnt = 0;
      m_tick_now = 0; m_out = 0; m_miss = 0;
    end else begin
      if (m_tick_now) begin
        if (m_out && !hs) m_miss = (m_miss == 255) ? 255 : m_miss + 1;
        m_out = 1;
      end else if (hs) begin
        m_out = 0;
      end
      m_tick_now = 0;
      if (fs) begin
        if (m_cnt == TF - 1) begin
          m_cnt = 0;
          m_tick_now = 1;
          exp_tick_q.push_back(cyc + 1);
        end else begin
          m_cnt++;
        end
        if (m_pend) begin
          if (m_stage != m_disp) exp_disp_q.push_back(m_stage);
          m_disp = m_stage;
          m_pend = 0;
        end
      end
      if (hs) begin
        m_stage = d;
        m_pend  = 1;
      end
    end
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0);
  endtask

  logic [73:0] d1, d2, da;
  int          t0;

  initial begin
    reset = 1'b1; frame_start = 1'b0; upd_valid = 1'b0;
    {upd_x, upd_y, upd_lpaddle, upd_rpaddle} = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("reset_ready", 74'(upd_ready), 74'(1));
    chk("reset_disp", {disp_x, disp_y, disp_lpaddle, disp_rpaddle}, '0);
    chk("reset_miss", 74'(miss_count), 74'(0));
    chk("reset_tick", 74'(game_tick), 74'(0));
    prev_disp = {disp_x, disp_y, disp_lpaddle, disp_rpaddle};
    mon_en = 1;
    @(posedge clk); #1;

    // Handshake then commit at the next frame_start.
    d1 = {5'd5, 5'd9, 32'h000F0000, 32'h0000_0000};
    step(0, 0, 1, d1);
    idle(3);
    step(0, 1, 0, '0);
    chk("commit_x", 74'(disp_x), 74'(5));
    chk("commit_lpaddle", 74'(disp_lpaddle), 74'(32'h000F0000));
    idle(1);

    // Handshake coinciding with frame_start in IDLE waits for the next frame.
    d2 = {5'd17, 5'd2, 32'h0000_00F0, 32'hF000_0000};
    step(0, 1, 1, d2);
    chk("no_bypass_x", 74'(disp_x), 74'(5));
    idle(2);
    step(0, 1, 0, '0);
    chk("late_commit_x", 74'(disp_x), 74'(17));

    // Tick cadence: 12 frame_starts from reset give 3 ticks.
    step(1, 0, 0, '0);
    t0 = ticks_seen;
    for (int i = 0; i < 12; i++) begin
      step(0, 1, 0, '0);
      idle(2);
    end
    chk("tick_count_12", 74'(ticks_seen - t0), 74'(3));

    // Miss saturation: 300 unanswered ticks, then answer once and tick again.
    step(1, 0, 0, '0);
    for (int i = 0; i < 300 * TF; i++) begin
      step(0, 1, 0, '0);
      idle(1);
    end
    idle(1);
    chk("miss_saturated", 74'(miss_count), 74'(255));
    step(0, 0, 1, rnd_data());
    for (int i = 0; i < TF; i++) begin
      step(0, 1, 0, '0);
      idle(1);
    end
    idle(1);
    chk("miss_no_wrap", 74'(miss_count), 74'(255));

    // Reset while PENDING discards the staged update.
    step(1, 0, 0, '0);
    step(0, 0, 1, {5'd3, 5'd1, 32'h1, 32'h2});
    step(1, 0, 0, '0);
    step(0, 1, 0, '0);
    idle(1);
    chk("discard_x", 74'(disp_x), 74'(0));
    chk("discard_ready", 74'(upd_ready), 74'(1));

    // PENDING stall: changing data with valid high is ignored until commit.
    da = {5'd21, 5'd30, 32'hA5A5_0000, 32'h0000_5A5A};
    step(0, 0, 1, da);
    for (int i = 0; i < 5; i++) step(0, 0, 1, rnd_data());
    step(0, 1, 1, rnd_data());
    chk("stall_commit", {disp_x, disp_y, disp_lpaddle, disp_rpaddle}, da);
    idle(1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 1) == 1), rnd_data());
    end
    idle(4);

    chk("disp_queue_drained", 74'(exp_disp_q.size()), 74'(0));
    chk("tick_queue_drained", 74'(exp_tick_q.size()), 74'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
